// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: function codes, FSM states and
// FLAGS bit positions. The 4-bit function encoding matches the control FSM.
package alu_pkg;

  localparam logic [3:0] FUN_ADD  = 4'h0;
  localparam logic [3:0] FUN_SUB  = 4'h1;
  localparam logic [3:0] FUN_MUL  = 4'h2;
  localparam logic [3:0] FUN_DIV  = 4'h3;
  localparam logic [3:0] FUN_AND  = 4'h4;
  localparam logic [3:0] FUN_OR   = 4'h5;
  localparam logic [3:0] FUN_NAND = 4'h6;
  localparam logic [3:0] FUN_NOR  = 4'h7;
  localparam logic [3:0] FUN_XOR  = 4'h8;
  localparam logic [3:0] FUN_XNOR = 4'h9;
  localparam logic [3:0] FUN_EQ   = 4'hA;
  localparam logic [3:0] FUN_GT   = 4'hB;
  localparam logic [3:0] FUN_LT   = 4'hC;
  localparam logic [3:0] FUN_SHR  = 4'hD;
  localparam logic [3:0] FUN_SHL  = 4'hE;
  localparam logic [3:0] FUN_ILL  = 4'hF;

  // IDLE accepts requests; DIV means the iterative divider owns the block.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } alu_state_e;

  // FLAGS = {DIV0, CARRY, ZERO}
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_DIV0  = 2;

  // True for a division that must go through the iterative path.
  function automatic logic needs_iter_div(input logic [3:0] fun, input logic divisor_zero);
    return (fun == FUN_DIV) && !divisor_zero;
  endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on operand
// magnitudes, sign fix-up applied combinationally on the final step so the
// parent can register the finished result on the same edge as that step.
module alu_div_iter
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         ovf
);

  localparam int            CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0]  ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dsr_q, dsr_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic          ovf_q, ovf_d;

  logic [W:0]    shifted;
  logic [W:0]    trial;
  logic [W-1:0]  rem_step;
  logic [W-1:0]  quo_step;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    trial   = shifted - {1'b0, dsr_q};
    if (trial[W]) begin
      rem_step = shifted[W-1:0];
      quo_step = {quo_q[W-2:0], 1'b0};
    end else begin
      rem_step = trial[W-1:0];
      quo_step = {quo_q[W-2:0], 1'b1};
    end
  end

  // Load magnitudes and signs on start, then iterate while busy.
  always_comb begin
    a_mag     = (is_signed && dividend[W-1]) ? (~dividend + ONE) : dividend;
    b_mag     = (is_signed && divisor[W-1])  ? (~divisor + ONE)  : divisor;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ovf_d     = ovf_q;
    if (start) begin
      busy_d    = 1'b1;
      cnt_d     = LAST;
      rem_d     = '0;
      quo_d     = a_mag;
      dsr_d     = b_mag;
      neg_quo_d = is_signed && (dividend[W-1] ^ divisor[W-1]);
      neg_rem_d = is_signed && dividend[W-1];
      // MIN / -1 cannot be represented; the magnitude path still yields MIN.
      ovf_d     = is_signed && (dividend == MIN) && (divisor == '1);
    end else if (busy_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ovf_q     <= ovf_d;
    end
  end

  // Final-step result with sign fix-up; only meaningful while done is high.
  always_comb begin
    busy = busy_q;
    done = busy_q && (cnt_q == '0);
    quot = neg_quo_q ? (~quo_step + ONE) : quo_step;
    rem  = neg_rem_q ? (~rem_step + ONE) : rem_step;
    ovf  = ovf_q;
  end

endmodule

// File: rtl/alu_pipe.sv
// Parametrised sequential ALU with valid/ready input, signed/unsigned mode,
// registered result and flags, and an iterative divider for division.
//
// Handshake: a request is accepted on a rising CLK edge when IN_VALID and
// IN_READY are both high; ALU_FUN, SIGNED, A and B are captured then.
// OUT_Valid is a single-cycle pulse per accepted request; ALU_OUT and FLAGS
// hold between pulses. IN_READY is low only while a division iterates.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int IN_Width  = 8,
  parameter int OUT_Width = IN_Width * 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic                 SIGNED,
  input  logic [3:0]           ALU_FUN,
  input  logic [IN_Width-1:0]  A,
  input  logic [IN_Width-1:0]  B,
  output logic [OUT_Width-1:0] ALU_OUT,
  output logic                 OUT_Valid,
  output logic [2:0]           FLAGS,
  output alu_state_e           DBG_STATE
);

  localparam int W  = IN_Width;
  localparam int OW = OUT_Width;

  alu_state_e     state_q, state_d;
  logic [OW-1:0]  alu_out_q, alu_out_d;
  logic [2:0]     flags_q, flags_d;
  logic           out_valid_q, out_valid_d;

  logic [W:0]     add_w;
  logic [W:0]     sub_w;
  logic [OW-1:0]  a_ext;
  logic [OW-1:0]  b_ext;
  logic [OW-1:0]  prod;
  logic [W-1:0]   a_cmp;
  logic [W-1:0]   b_cmp;
  logic [W-1:0]   shr_w;
  logic [OW-1:0]  res_sc;
  logic           carry_sc;
  logic           div0_sc;

  logic           div_start;
  logic           div_busy;
  logic           div_done;
  logic [W-1:0]   div_quot;
  logic [W-1:0]   div_rem;
  logic           div_ovf;

  // Operand preparation shared by the single-cycle operations.
  always_comb begin
    a_ext = SIGNED ? {{(OW-W){A[W-1]}}, A} : {{(OW-W){1'b0}}, A};
    b_ext = SIGNED ? {{(OW-W){B[W-1]}}, B} : {{(OW-W){1'b0}}, B};
    add_w = {SIGNED & A[W-1], A} + {SIGNED & B[W-1], B};
    sub_w = {SIGNED & A[W-1], A} - {SIGNED & B[W-1], B};
    // Low 2W bits of the extended product are correct for both modes.
    prod  = a_ext * b_ext;
    // Flipping the MSB in signed mode turns a signed compare into unsigned.
    a_cmp = {A[W-1] ^ SIGNED, A[W-2:0]};
    b_cmp = {B[W-1] ^ SIGNED, B[W-2:0]};
    shr_w = {SIGNED & A[W-1], A[W-1:1]};
  end

  // Single-cycle result, carry and divide-by-zero for the current request.
  always_comb begin
    res_sc   = '0;
    carry_sc = 1'b0;
    div0_sc  = 1'b0;
    case (ALU_FUN)
      FUN_ADD: begin
        res_sc   = SIGNED ? {{(OW-W-1){add_w[W]}}, add_w} : {{(OW-W-1){1'b0}}, add_w};
        carry_sc = SIGNED ? (add_w[W] ^ add_w[W-1]) : add_w[W];
      end
      FUN_SUB: begin
        res_sc   = SIGNED ? {{(OW-W-1){sub_w[W]}}, sub_w} : {{(OW-W-1){1'b0}}, sub_w};
        carry_sc = SIGNED ? (sub_w[W] ^ sub_w[W-1]) : sub_w[W];
      end
      FUN_MUL:  res_sc = prod;
      FUN_DIV:  div0_sc = (B == '0);
      FUN_AND:  res_sc = {{(OW-W){1'b0}}, A & B};
      FUN_OR:   res_sc = {{(OW-W){1'b0}}, A | B};
      FUN_NAND: res_sc = {{(OW-W){1'b0}}, ~(A & B)};
      FUN_NOR:  res_sc = {{(OW-W){1'b0}}, ~(A | B)};
      FUN_XOR:  res_sc = {{(OW-W){1'b0}}, A ^ B};
      FUN_XNOR: res_sc = {{(OW-W){1'b0}}, ~(A ^ B)};
      FUN_EQ:   res_sc = (A == B) ? OW'(1) : '0;
      FUN_GT:   res_sc = (a_cmp > b_cmp) ? OW'(2) : '0;
      FUN_LT:   res_sc = (a_cmp < b_cmp) ? OW'(3) : '0;
      FUN_SHR:  res_sc = {{(OW-W){1'b0}}, shr_w};
      FUN_SHL:  res_sc = {{(OW-W-1){1'b0}}, A, 1'b0};
      FUN_ILL:  res_sc = '0;
      default:  res_sc = '0;
    endcase
  end

  // Handshake, FSM next state and output register updates.
  always_comb begin
    state_d     = state_q;
    alu_out_d   = alu_out_q;
    flags_d     = flags_q;
    out_valid_d = 1'b0;
    div_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          if (needs_iter_div(ALU_FUN, B == '0)) begin
            div_start = 1'b1;
            state_d   = ST_DIV;
          end else begin
            alu_out_d            = res_sc;
            flags_d              = '0;
            flags_d[FLAG_ZERO]   = (res_sc == '0);
            flags_d[FLAG_CARRY]  = carry_sc;
            flags_d[FLAG_DIV0]   = div0_sc;
            out_valid_d          = 1'b1;
          end
        end
      end
      ST_DIV: begin
        if (div_done) begin
          state_d             = ST_IDLE;
          alu_out_d           = {div_rem, div_quot};
          flags_d             = '0;
          flags_d[FLAG_ZERO]  = ({div_rem, div_quot} == '0);
          flags_d[FLAG_CARRY] = div_ovf;
          out_valid_d         = 1'b1;
        end else if (!div_busy) begin
          // Divider idle without finishing: recover rather than hang.
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      alu_out_q   <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_out_q   <= alu_out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  alu_div_iter #(
    .W (W)
  ) u_div (
    .clk       (CLK),
    .rst_n     (RST),
    .start     (div_start),
    .is_signed (SIGNED),
    .dividend  (A),
    .divisor   (B),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem),
    .ovf       (div_ovf)
  );

  // Output wiring; IN_READY follows the registered state.
  always_comb begin
    IN_READY  = (state_q == ST_IDLE);
    ALU_OUT   = alu_out_q;
    OUT_Valid = out_valid_q;
    FLAGS     = flags_q;
    DBG_STATE = state_q;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at W = 8: a table of single-cycle vectors
// streamed back to back, then hand-written division, busy-window and
// mid-division reset sequences.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int NV = 28;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic           sgn;
  logic [3:0]     fun;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] alu_out;
  logic           out_valid;
  logic [2:0]     flags;
  alu_state_e     dbg_state;

  int n_checks;
  int n_pass;

  typedef struct {
    logic           sgn;
    logic [3:0]     fun;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_out;
    logic [2:0]     exp_flags;
  } vec_t;

  vec_t           vecs[NV];
  logic [2*W-1:0] exp_q[$];

  alu_pipe #(
    .IN_Width  (W),
    .OUT_Width (2*W)
  ) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .SIGNED    (sgn),
    .ALU_FUN   (fun),
    .A         (a),
    .B         (b),
    .ALU_OUT   (alu_out),
    .OUT_Valid (out_valid),
    .FLAGS     (flags),
    .DBG_STATE (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] f,
                       input logic [W-1:0] da, input logic [W-1:0] db);
    in_valid = v;
    sgn      = s;
    fun      = f;
    a        = da;
    b        = db;
  endtask

  // Full division transaction: ready low for W cycles, result at W+1.
  task automatic do_div(input string tag, input logic s, input logic [W-1:0] da,
                        input logic [W-1:0] db, input logic [2*W-1:0] eo,
                        input logic [2:0] ef);
    drive(1'b1, s, FUN_DIV, da, db);
    tick();
    // Scramble operands after accept; the in-flight division must ignore them.
    drive(1'b0, ~s, FUN_DIV, ~da, 8'h01);
    for (int k = 0; k < W; k++) begin
      check($sformatf("%s_busy%0d", tag, k), {30'd0, in_ready, out_valid}, 32'd0);
      tick();
    end
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_out"}, {16'd0, alu_out}, {16'd0, eo});
    check({tag, "_flags"}, {29'd0, flags}, {29'd0, ef});
    tick();
    check({tag, "_pulse_end"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    //               sgn   fun       a      b      out       {DIV0,CARRY,ZERO}
    vecs[0]  = '{1'b0, FUN_ADD,  8'hFF, 8'h01, 16'h0100, 3'b010};
    vecs[1]  = '{1'b0, FUN_SUB,  8'h03, 8'h05, 16'h01FE, 3'b010};
    vecs[2]  = '{1'b1, FUN_SUB,  8'h80, 8'h01, 16'hFF7F, 3'b010};
    vecs[3]  = '{1'b1, FUN_MUL,  8'hFD, 8'h05, 16'hFFF1, 3'b000};
    vecs[4]  = '{1'b0, FUN_MUL,  8'hFF, 8'hFF, 16'hFE01, 3'b000};
    vecs[5]  = '{1'b0, FUN_DIV,  8'h09, 8'h00, 16'h0000, 3'b101};
    vecs[6]  = '{1'b0, FUN_AND,  8'hF0, 8'h3C, 16'h0030, 3'b000};
    vecs[7]  = '{1'b0, FUN_OR,   8'hF0, 8'h3C, 16'h00FC, 3'b000};
    vecs[8]  = '{1'b0, FUN_NAND, 8'hF0, 8'h3C, 16'h00CF, 3'b000};
    vecs[9]  = '{1'b0, FUN_NOR,  8'hF0, 8'h3C, 16'h0003, 3'b000};
    vecs[10] = '{1'b0, FUN_XOR,  8'hF0, 8'h3C, 16'h00CC, 3'b000};
    vecs[11] = '{1'b0, FUN_XNOR, 8'hF0, 8'h3C, 16'h0033, 3'b000};
    vecs[12] = '{1'b0, FUN_EQ,   8'h05, 8'h05, 16'h0001, 3'b000};
    vecs[13] = '{1'b0, FUN_EQ,   8'h05, 8'h06, 16'h0000, 3'b001};
    vecs[14] = '{1'b1, FUN_GT,   8'h01, 8'hFF, 16'h0002, 3'b000};
    vecs[15] = '{1'b0, FUN_GT,   8'h01, 8'hFF, 16'h0000, 3'b001};
    vecs[16] = '{1'b1, FUN_LT,   8'h80, 8'h01, 16'h0003, 3'b000};
    vecs[17] = '{1'b0, FUN_LT,   8'h80, 8'h01, 16'h0000, 3'b001};
    vecs[18] = '{1'b1, FUN_SHR,  8'h81, 8'h00, 16'h00C0, 3'b000};
    vecs[19] = '{1'b0, FUN_SHR,  8'h81, 8'h00, 16'h0040, 3'b000};
    vecs[20] = '{1'b0, FUN_SHL,  8'h81, 8'h00, 16'h0102, 3'b000};
    vecs[21] = '{1'b0, FUN_ILL,  8'h12, 8'h34, 16'h0000, 3'b001};
    vecs[22] = '{1'b1, FUN_ADD,  8'h7F, 8'h01, 16'h0080, 3'b010};
    vecs[23] = '{1'b1, FUN_ADD,  8'hFF, 8'hFF, 16'hFFFE, 3'b000};
    vecs[24] = '{1'b0, FUN_ADD,  8'h00, 8'h00, 16'h0000, 3'b001};
    vecs[25] = '{1'b1, FUN_DIV,  8'h05, 8'h00, 16'h0000, 3'b101};
    vecs[26] = '{1'b1, FUN_MUL,  8'h80, 8'h80, 16'h4000, 3'b000};
    vecs[27] = '{1'b0, FUN_SUB,  8'h05, 8'h03, 16'h0002, 3'b000};

    // Reset values
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", {16'd0, alu_out}, 32'd0);
    check("reset_flags", {29'd0, flags}, 32'd0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_ready", {31'd0, in_ready}, 32'd1);
    check("reset_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
    rst_n = 1'b1;
    tick();

    // Table vectors streamed back to back: one pulse per accept
    drive(1'b1, vecs[0].sgn, vecs[0].fun, vecs[0].a, vecs[0].b);
    exp_q.push_back(vecs[0].exp_out);
    for (int i = 0; i < NV; i++) begin
      tick();
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      if (exp_q.size() > 0)
        check($sformatf("vec%0d_out", i), {16'd0, alu_out}, {16'd0, exp_q.pop_front()});
      check($sformatf("vec%0d_flags", i), {29'd0, flags}, {29'd0, vecs[i].exp_flags});
      if (i + 1 < NV) begin
        drive(1'b1, vecs[i+1].sgn, vecs[i+1].fun, vecs[i+1].a, vecs[i+1].b);
        exp_q.push_back(vecs[i+1].exp_out);
      end else begin
        in_valid = 1'b0;
      end
    end
    tick();
    check("stream_pulse_end", {31'd0, out_valid}, 32'd0);
    check("stream_hold_out", {16'd0, alu_out}, {16'd0, vecs[NV-1].exp_out});
    tick();
    check("idle_no_pulse", {31'd0, out_valid}, 32'd0);

    // Iterative divisions
    do_div("udiv_200_7",   1'b0, 8'd200, 8'd7,  16'h041C, 3'b000);
    do_div("sdiv_m7_2",    1'b1, 8'hF9,  8'h02, 16'hFFFD, 3'b000);
    do_div("sdiv_7_m2",    1'b1, 8'h07,  8'hFE, 16'h01FD, 3'b000);
    do_div("sdiv_min_m1",  1'b1, 8'h80,  8'hFF, 16'h0080, 3'b010);
    do_div("udiv_0_5",     1'b0, 8'h00,  8'h05, 16'h0000, 3'b001);
    do_div("udiv_255_1",   1'b0, 8'hFF,  8'h01, 16'h00FF, 3'b000);
    do_div("udiv_6_3",     1'b0, 8'h06,  8'h03, 16'h0002, 3'b000);

    // Request held during the busy window is taken only once ready returns
    drive(1'b1, 1'b0, FUN_DIV, 8'd200, 8'd7);
    tick();
    drive(1'b1, 1'b0, FUN_XOR, 8'hF0, 8'h3C);
    for (int k = 0; k < W; k++) begin
      check($sformatf("held_busy%0d", k), {30'd0, in_ready, out_valid}, 32'd0);
      tick();
    end
    check("held_div_valid", {31'd0, out_valid}, 32'd1);
    check("held_div_out", {16'd0, alu_out}, 32'h041C);
    check("held_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("held_xor_valid", {31'd0, out_valid}, 32'd1);
    check("held_xor_out", {16'd0, alu_out}, 32'h00CC);
    check("held_xor_flags", {29'd0, flags}, 32'd0);
    in_valid = 1'b0;
    tick();
    check("held_pulse_end", {31'd0, out_valid}, 32'd0);

    // Leave non-zero output and flags before the abort test
    drive(1'b1, 1'b0, FUN_ADD, 8'hFF, 8'h01);
    tick();
    in_valid = 1'b0;
    check("pre_abort_out", {16'd0, alu_out}, 32'h0100);

    // Reset asserted in cycle 4 of a division
    drive(1'b1, 1'b0, FUN_DIV, 8'd200, 8'd7);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("abort_state_div", {31'd0, dbg_state}, {31'd0, ST_DIV});
    rst_n = 1'b0;
    #1;
    check("abort_out", {16'd0, alu_out}, 32'd0);
    check("abort_flags", {29'd0, flags}, 32'd0);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < W + 2; k++) begin
      tick();
      check($sformatf("abort_quiet%0d", k), {31'd0, out_valid}, 32'd0);
    end
    check("abort_out_stays", {16'd0, alu_out}, 32'd0);
    drive(1'b1, 1'b0, FUN_XOR, 8'hF0, 8'h3C);
    tick();
    in_valid = 1'b0;
    check("post_abort_valid", {31'd0, out_valid}, 32'd1);
    check("post_abort_out", {16'd0, alu_out}, 32'h00CC);
    tick();
    check("post_abort_pulse_end", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
